// File: rtl/bilinear_pkg.sv
// Shared definitions for the bilinear downscale job controller: CSR word
// addresses, IRQ flag bit indices, FSM state encoding, the job descriptor
// payload and the descriptor validation rule.
package bilinear_pkg;

    localparam int unsigned CSR_AW  = 4;
    localparam int unsigned CSR_DW  = 32;
    localparam int unsigned FIELD_W = 16;
    localparam int unsigned MODE_W  = 8;
    localparam int unsigned IRQ_W   = 4;

    localparam logic [CSR_AW-1:0] ADDR_CTRL      = 4'd0;
    localparam logic [CSR_AW-1:0] ADDR_STATUS    = 4'd1;
    localparam logic [CSR_AW-1:0] ADDR_IRQ       = 4'd2;
    localparam logic [CSR_AW-1:0] ADDR_SCALE_Q   = 4'd3;
    localparam logic [CSR_AW-1:0] ADDR_IN_W_H    = 4'd4;
    localparam logic [CSR_AW-1:0] ADDR_OUT_W_H   = 4'd5;
    localparam logic [CSR_AW-1:0] ADDR_PUSH      = 4'd6;
    localparam logic [CSR_AW-1:0] ADDR_PERF_CYC  = 4'd7;
    localparam logic [CSR_AW-1:0] ADDR_PERF_PIX  = 4'd8;
    localparam logic [CSR_AW-1:0] ADDR_JOBS_DONE = 4'd9;

    localparam int unsigned IRQ_DONE    = 0;
    localparam int unsigned IRQ_ERR_CFG = 1;
    localparam int unsigned IRQ_OVF     = 2;
    localparam int unsigned IRQ_TMO     = 3;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        LAUNCH = 2'd1,
        RUN    = 2'd2
    } state_t;

    typedef struct packed {
        logic [MODE_W-1:0]  mode;
        logic [FIELD_W-1:0] scale_q;
        logic [FIELD_W-1:0] in_w;
        logic [FIELD_W-1:0] in_h;
        logic [FIELD_W-1:0] out_w;
        logic [FIELD_W-1:0] out_h;
    } desc_t;

    // A descriptor is runnable when every dimension is nonzero, the input fits
    // the core line buffers, the job only downscales, and it targets a real core.
    function automatic logic desc_valid(input desc_t d, input int unsigned w_max,
                                        input int unsigned h_max, input int unsigned ncore);
        logic nonzero;
        logic fits;
        logic shrinks;
        logic target_ok;
        nonzero   = (d.in_w != '0) && (d.in_h != '0) && (d.out_w != '0) && (d.out_h != '0);
        fits      = (32'(d.in_w) <= w_max) && (32'(d.in_h) <= h_max);
        shrinks   = (d.out_w <= d.in_w) && (d.out_h <= d.in_h);
        target_ok = (d.scale_q != '0) && (32'(d.mode) < ncore);
        return nonzero && fits && shrinks && target_ok;
    endfunction

endpackage

// File: rtl/bilinear_desc_fifo.sv
// Descriptor queue of depth QDEPTH (power of 2, >= 2).
// Ports: push/push_data enqueue; pop dequeues the head shown on pop_data_c;
// full/empty/count are registered occupancy status. A push while full is
// accepted when a pop happens in the same cycle.
module bilinear_desc_fifo
    import bilinear_pkg::*;
#(
    parameter  int unsigned QDEPTH = 4,
    localparam int unsigned CNT_W  = $clog2(QDEPTH) + 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  desc_t            push_data,
    input  logic             pop,
    output desc_t            pop_data_c,
    output logic             full,
    output logic             empty,
    output logic [CNT_W-1:0] count
);

    localparam int unsigned PTR_W = $clog2(QDEPTH);

    desc_t            mem [QDEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic             do_push;
    logic             do_pop;
    logic [CNT_W-1:0] count_nxt;

    // Accept/advance decisions and next occupancy.
    always_comb begin
        do_pop    = pop && !empty;
        do_push   = push && (!full || do_pop);
        count_nxt = count + CNT_W'(do_push) - CNT_W'(do_pop);
    end

    assign pop_data_c = mem[rd_ptr];

    // Storage array carries no reset; only pointers and flags do.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= push_data;
        end
    end

    // Pointers and registered occupancy flags.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            full   <= 1'b0;
            empty  <= 1'b1;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            count <= count_nxt;
            full  <= (count_nxt == CNT_W'(QDEPTH));
            empty <= (count_nxt == '0);
        end
    end

endmodule

// File: rtl/bilinear_job_ctrl.sv
// CSR and job-control front end for the bilinear downscale cores.
// Ports: csr_we/csr_addr/csr_wdata write the CSR file, csr_rdata reads it
// combinationally; core_start/core_done handshake with NCORE cores (core_busy
// is reported in STATUS[31:24]); pix_inc feeds the pixel counter; job_* carry
// the active descriptor; irq is the enabled OR of the sticky W1C flags.
module bilinear_job_ctrl
    import bilinear_pkg::*;
#(
    parameter int unsigned NCORE   = 2,
    parameter int unsigned QDEPTH  = 4,
    parameter int unsigned W_MAX   = 64,
    parameter int unsigned H_MAX   = 64,
    parameter int unsigned TIMEOUT = 65535
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                csr_we,
    input  logic [CSR_AW-1:0]   csr_addr,
    input  logic [CSR_DW-1:0]   csr_wdata,
    output logic [CSR_DW-1:0]   csr_rdata,
    output logic                irq,
    output logic [NCORE-1:0]    core_start,
    input  logic [NCORE-1:0]    core_busy,
    input  logic [NCORE-1:0]    core_done,
    input  logic [7:0]          pix_inc,
    output logic [FIELD_W-1:0]  job_in_w,
    output logic [FIELD_W-1:0]  job_in_h,
    output logic [FIELD_W-1:0]  job_out_w,
    output logic [FIELD_W-1:0]  job_out_h,
    output logic [FIELD_W-1:0]  job_scale_q
);

    localparam int unsigned CNT_W = $clog2(QDEPTH) + 1;
    localparam int unsigned WD_W  = $clog2(TIMEOUT + 1);

    // CSR state
    logic               ctrl_en;
    logic               ctrl_irq_en;
    logic [MODE_W-1:0]  ctrl_mode;
    logic [FIELD_W-1:0] scale_q;
    logic [FIELD_W-1:0] in_w;
    logic [FIELD_W-1:0] in_h;
    logic [FIELD_W-1:0] out_w;
    logic [FIELD_W-1:0] out_h;
    logic [IRQ_W-1:0]   irq_flags;
    logic [CSR_DW-1:0]  perf_cyc;
    logic [CSR_DW-1:0]  perf_pix;
    logic [CSR_DW-1:0]  jobs_done;
    logic [MODE_W-1:0]  act_mode;

    // FSM state
    state_t             state;
    state_t             state_nxt;
    logic [WD_W-1:0]    wdog;
    logic [WD_W-1:0]    wdog_nxt;

    // Combinational helpers
    logic               wr_ctrl, wr_irq, wr_scale, wr_in, wr_out, wr_push, wr_perf;
    desc_t              push_desc;
    logic               push_ok;
    logic               q_pop;
    desc_t              q_head;
    logic               q_full;
    logic               q_empty;
    logic [CNT_W-1:0]   q_count;
    logic               launch;
    logic               done_sel;
    logic               done_evt;
    logic               tmo_evt;
    logic [IRQ_W-1:0]   irq_set;
    logic [IRQ_W-1:0]   irq_flags_nxt;
    logic               irq_en_nxt;
    logic [CSR_DW:0]    pix_sum;
    logic [CSR_DW-1:0]  perf_cyc_nxt;
    logic [CSR_DW-1:0]  perf_pix_nxt;

    // Write decode and descriptor snapshot from the live CSRs.
    always_comb begin
        wr_ctrl   = csr_we && (csr_addr == ADDR_CTRL);
        wr_irq    = csr_we && (csr_addr == ADDR_IRQ);
        wr_scale  = csr_we && (csr_addr == ADDR_SCALE_Q);
        wr_in     = csr_we && (csr_addr == ADDR_IN_W_H);
        wr_out    = csr_we && (csr_addr == ADDR_OUT_W_H);
        wr_push   = csr_we && (csr_addr == ADDR_PUSH);
        wr_perf   = csr_we && (csr_addr == ADDR_PERF_CYC);
        push_desc = '{mode: ctrl_mode, scale_q: scale_q, in_w: in_w, in_h: in_h,
                      out_w: out_w, out_h: out_h};
        push_ok   = wr_push && desc_valid(push_desc, W_MAX, H_MAX, NCORE);
        q_pop     = (state == LAUNCH);
    end

    bilinear_desc_fifo #(
        .QDEPTH (QDEPTH)
    ) u_fifo (
        .clk        (clk),
        .rst_n      (rst_n),
        .push       (push_ok),
        .push_data  (push_desc),
        .pop        (q_pop),
        .pop_data_c (q_head),
        .full       (q_full),
        .empty      (q_empty),
        .count      (q_count)
    );

    // Only the active core's done is honoured.
    assign done_sel = |(core_done & (NCORE'(1) << act_mode));

    // Next-state logic; wdog holds the number of completed RUN cycles, so
    // wdog == TIMEOUT-1 means this is the TIMEOUT-th RUN cycle. Done wins a tie.
    always_comb begin
        state_nxt = state;
        wdog_nxt  = wdog;
        done_evt  = 1'b0;
        tmo_evt   = 1'b0;
        case (state)
            IDLE: begin
                if (ctrl_en && !q_empty) begin
                    state_nxt = LAUNCH;
                end
            end
            LAUNCH: begin
                state_nxt = RUN;
                wdog_nxt  = '0;
            end
            RUN: begin
                if (done_sel) begin
                    done_evt  = 1'b1;
                    state_nxt = IDLE;
                end else if (wdog == WD_W'(TIMEOUT - 1)) begin
                    tmo_evt   = 1'b1;
                    state_nxt = IDLE;
                end else begin
                    wdog_nxt = wdog + WD_W'(1);
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    assign launch = (state == IDLE) && (state_nxt == LAUNCH);

    // Sticky flags: a set in the same cycle as its W1C clear wins.
    always_comb begin
        irq_set              = '0;
        irq_set[IRQ_DONE]    = done_evt;
        irq_set[IRQ_ERR_CFG] = wr_push && !push_ok;
        irq_set[IRQ_OVF]     = push_ok && q_full && !q_pop;
        irq_set[IRQ_TMO]     = tmo_evt;
        irq_flags_nxt        = (irq_flags & ~(wr_irq ? csr_wdata[IRQ_W-1:0] : IRQ_W'(0))) | irq_set;
        irq_en_nxt           = wr_ctrl ? csr_wdata[1] : ctrl_irq_en;
    end

    // Saturating performance counters, cleared by a PERF_CYC write.
    always_comb begin
        pix_sum      = {1'b0, perf_pix} + (CSR_DW+1)'(pix_inc);
        perf_cyc_nxt = perf_cyc;
        perf_pix_nxt = perf_pix;
        if (wr_perf) begin
            perf_cyc_nxt = '0;
            perf_pix_nxt = '0;
        end else if (state == RUN) begin
            perf_cyc_nxt = (perf_cyc == '1) ? perf_cyc : perf_cyc + 32'd1;
            perf_pix_nxt = pix_sum[CSR_DW] ? '1 : pix_sum[CSR_DW-1:0];
        end
    end

    // FSM state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            wdog  <= '0;
        end else begin
            state <= state_nxt;
            wdog  <= wdog_nxt;
        end
    end

    // CSR file, counters and registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ctrl_en     <= 1'b0;
            ctrl_irq_en <= 1'b0;
            ctrl_mode   <= '0;
            scale_q     <= '0;
            in_w        <= '0;
            in_h        <= '0;
            out_w       <= '0;
            out_h       <= '0;
            irq_flags   <= '0;
            irq         <= 1'b0;
            perf_cyc    <= '0;
            perf_pix    <= '0;
            jobs_done   <= '0;
            act_mode    <= '0;
            core_start  <= '0;
            job_in_w    <= '0;
            job_in_h    <= '0;
            job_out_w   <= '0;
            job_out_h   <= '0;
            job_scale_q <= '0;
        end else begin
            if (wr_ctrl) begin
                ctrl_en     <= csr_wdata[0];
                ctrl_irq_en <= csr_wdata[1];
                ctrl_mode   <= csr_wdata[15:8];
            end
            if (wr_scale) begin
                scale_q <= csr_wdata[15:0];
            end
            if (wr_in) begin
                in_w <= csr_wdata[31:16];
                in_h <= csr_wdata[15:0];
            end
            if (wr_out) begin
                out_w <= csr_wdata[31:16];
                out_h <= csr_wdata[15:0];
            end
            irq_flags <= irq_flags_nxt;
            irq       <= irq_en_nxt & (|irq_flags_nxt);
            perf_cyc  <= perf_cyc_nxt;
            perf_pix  <= perf_pix_nxt;
            if (done_evt) begin
                jobs_done <= jobs_done + 32'd1;
            end
            // Job fields and the start pulse go out together on entry to LAUNCH.
            core_start <= '0;
            if (launch) begin
                core_start  <= NCORE'(1) << q_head.mode;
                act_mode    <= q_head.mode;
                job_in_w    <= q_head.in_w;
                job_in_h    <= q_head.in_h;
                job_out_w   <= q_head.out_w;
                job_out_h   <= q_head.out_h;
                job_scale_q <= q_head.scale_q;
            end
        end
    end

    // CSR read mux.
    always_comb begin
        csr_rdata = '0;
        case (csr_addr)
            ADDR_CTRL:      csr_rdata = {16'h0, ctrl_mode, 6'h0, ctrl_irq_en, ctrl_en};
            ADDR_STATUS:    csr_rdata = {8'(core_busy), act_mode, 8'(q_count), 5'h0,
                                         q_empty, q_full, (state != IDLE)};
            ADDR_IRQ:       csr_rdata = CSR_DW'(irq_flags);
            ADDR_SCALE_Q:   csr_rdata = {16'h0, scale_q};
            ADDR_IN_W_H:    csr_rdata = {in_w, in_h};
            ADDR_OUT_W_H:   csr_rdata = {out_w, out_h};
            ADDR_PERF_CYC:  csr_rdata = perf_cyc;
            ADDR_PERF_PIX:  csr_rdata = perf_pix;
            ADDR_JOBS_DONE: csr_rdata = jobs_done;
            default:        csr_rdata = '0;
        endcase
    end

endmodule

// File: tb/tb_bilinear_job_ctrl.sv
// Self-checking bench for bilinear_job_ctrl: accepted descriptors are queued
// in a scoreboard and compared against core_start/job_* at each launch.
module tb_bilinear_job_ctrl;
    import bilinear_pkg::*;

    localparam int unsigned NCORE   = 2;
    localparam int unsigned TMO_CYC = 16;

    logic               clk = 1'b0;
    logic               rst_n = 1'b0;
    logic               csr_we = 1'b0;
    logic [CSR_AW-1:0]  csr_addr = '0;
    logic [CSR_DW-1:0]  csr_wdata = '0;
    logic [CSR_DW-1:0]  csr_rdata;
    logic               irq;
    logic [NCORE-1:0]   core_start;
    logic [NCORE-1:0]   core_busy = '0;
    logic [NCORE-1:0]   core_done = '0;
    logic [7:0]         pix_inc = '0;
    logic [FIELD_W-1:0] job_in_w, job_in_h, job_out_w, job_out_h, job_scale_q;

    int    n_checks = 0;
    int    n_errors = 0;
    desc_t exp_q[$];
    desc_t mon_d;
    logic  b_en = 1'b0;
    logic  b_irq_en = 1'b0;

    bilinear_job_ctrl #(
        .NCORE(NCORE), .QDEPTH(4), .W_MAX(64), .H_MAX(64), .TIMEOUT(TMO_CYC)
    ) dut (
        .clk(clk), .rst_n(rst_n), .csr_we(csr_we), .csr_addr(csr_addr),
        .csr_wdata(csr_wdata), .csr_rdata(csr_rdata), .irq(irq),
        .core_start(core_start), .core_busy(core_busy), .core_done(core_done),
        .pix_inc(pix_inc), .job_in_w(job_in_w), .job_in_h(job_in_h),
        .job_out_w(job_out_w), .job_out_h(job_out_h), .job_scale_q(job_scale_q)
    );

    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic csr_wr(input logic [3:0] a, input logic [31:0] d);
        csr_we = 1'b1; csr_addr = a; csr_wdata = d;
        tick();
        csr_we = 1'b0; csr_wdata = '0;
    endtask

    task automatic check_csr(input string tag, input logic [3:0] a, input logic [31:0] exp);
        csr_addr = a;
        #1;
        check_val(tag, csr_rdata, exp);
    endtask

    function automatic desc_t mk_desc(input logic [7:0] m, input logic [15:0] s,
                                      input logic [15:0] iw, input logic [15:0] ih,
                                      input logic [15:0] ow, input logic [15:0] oh);
        desc_t d;
        d.mode = m; d.scale_q = s; d.in_w = iw; d.in_h = ih; d.out_w = ow; d.out_h = oh;
        return d;
    endfunction

    task automatic load_desc(input desc_t d);
        csr_wr(ADDR_CTRL, {16'h0, d.mode, 6'h0, b_irq_en, b_en});
        csr_wr(ADDR_SCALE_Q, {16'h0, d.scale_q});
        csr_wr(ADDR_IN_W_H, {d.in_w, d.in_h});
        csr_wr(ADDR_OUT_W_H, {d.out_w, d.out_h});
    endtask

    task automatic push_desc(input desc_t d, input bit accept);
        load_desc(d);
        if (accept) exp_q.push_back(d);
        csr_wr(ADDR_PUSH, 32'h0);
    endtask

    // Waits for a launch, then runs ncyc RUN cycles with done on the last one.
    task automatic run_job(input int ncyc, input logic [7:0] pix, input bit clr_done, output int gap);
        logic [NCORE-1:0] cs;
        int w;
        w = 0;
        while (core_start === '0 && w < 40) begin
            tick();
            w++;
        end
        gap = w;
        check_val("launch_seen", 32'(core_start != '0), 32'd1);
        if (core_start === '0) return;
        cs = core_start;
        tick();
        pix_inc = pix;
        for (int i = 1; i <= ncyc; i++) begin
            if (i == ncyc) begin
                core_done = cs;
                if (clr_done) begin
                    csr_we = 1'b1; csr_addr = ADDR_IRQ; csr_wdata = 32'h1;
                end
            end
            tick();
        end
        core_done = '0; pix_inc = '0; csr_we = 1'b0; csr_wdata = '0;
    endtask

    // Scoreboard: every launch must match the oldest accepted descriptor.
    always @(posedge clk) begin
        #1;
        if (core_start !== '0) begin
            if (exp_q.size() == 0) begin
                check_val("start_unexpected", 32'(core_start), 32'd0);
            end else begin
                mon_d = exp_q.pop_front();
                check_val("start_onehot", 32'(core_start), 32'd1 << mon_d.mode);
                check_val("job_in_w", 32'(job_in_w), 32'(mon_d.in_w));
                check_val("job_in_h", 32'(job_in_h), 32'(mon_d.in_h));
                check_val("job_out_w", 32'(job_out_w), 32'(mon_d.out_w));
                check_val("job_out_h", 32'(job_out_h), 32'(mon_d.out_h));
                check_val("job_scale_q", 32'(job_scale_q), 32'(mon_d.scale_q));
            end
        end
    end

    initial begin
        #400000;
        $display("FAIL global_timeout: simulation did not reach the end");
        $fatal(1, "timeout");
    end

    initial begin
        desc_t g, d6, wd, rj;
        desc_t ql[4];
        logic [NCORE-1:0] cs;
        int w;
        int gap;

        // Reset values
        repeat (2) tick();
        check_val("rst_irq", 32'(irq), 32'd0);
        check_val("rst_core_start", 32'(core_start), 32'd0);
        check_val("rst_job_in_w", 32'(job_in_w), 32'd0);
        check_csr("rst_status", ADDR_STATUS, 32'h0000_0004);
        check_csr("rst_ctrl", ADDR_CTRL, 32'h0);
        rst_n = 1'b1;
        tick();

        // Single job with exact launch timing
        b_en = 1'b1; b_irq_en = 1'b1;
        g = mk_desc(8'd1, 16'h0200, 16'd64, 16'd64, 16'd32, 16'd32);
        load_desc(g);
        exp_q.push_back(g);
        csr_wr(ADDR_PUSH, 32'h0);
        check_val("t1_start_c1", 32'(core_start), 32'd0);
        check_csr("t1_status_c1", ADDR_STATUS, 32'h0000_0100);
        tick();
        check_val("t1_start_c2", 32'(core_start), 32'h2);
        check_csr("t1_status_launch", ADDR_STATUS, 32'h0001_0101);
        core_done = 2'b10;
        tick();
        core_done = '0; pix_inc = 8'd4;
        for (int i = 1; i <= 10; i++) begin
            if (i == 10) core_done = 2'b10;
            tick();
        end
        core_done = '0; pix_inc = '0;
        check_csr("t1_status_idle", ADDR_STATUS, 32'h0001_0004);
        check_csr("t1_perf_cyc", ADDR_PERF_CYC, 32'd10);
        check_csr("t1_perf_pix", ADDR_PERF_PIX, 32'd40);
        check_csr("t1_jobs_done", ADDR_JOBS_DONE, 32'd1);
        check_csr("t1_irq_flags", ADDR_IRQ, 32'h1);
        check_val("t1_irq", 32'(irq), 32'd1);
        csr_wr(ADDR_IRQ, 32'h1);
        check_val("t1_irq_cleared", 32'(irq), 32'd0);

        // Validation rejects
        b_en = 1'b0;
        for (int k = 0; k < 4; k++) begin
            case (k)
                0:       g = mk_desc(8'd1, 16'h0200, 16'd64, 16'd64, 16'd0,  16'd32);
                1:       g = mk_desc(8'd1, 16'h0200, 16'd65, 16'd64, 16'd32, 16'd32);
                2:       g = mk_desc(8'd1, 16'h0200, 16'd40, 16'd40, 16'd41, 16'd20);
                default: g = mk_desc(8'd2, 16'h0200, 16'd64, 16'd64, 16'd32, 16'd32);
            endcase
            push_desc(g, 1'b0);
            check_csr($sformatf("t2_err_cfg_%0d", k), ADDR_IRQ, 32'h2);
            check_csr($sformatf("t2_status_%0d", k), ADDR_STATUS, 32'h0001_0004);
            csr_wr(ADDR_IRQ, 32'h2);
        end

        // Queue full, overflow, push at full during LAUNCH
        ql[0] = mk_desc(8'd0, 16'h0100, 16'd64, 16'd64, 16'd64, 16'd64);
        ql[1] = mk_desc(8'd1, 16'h0180, 16'd48, 16'd32, 16'd24, 16'd16);
        ql[2] = mk_desc(8'd0, 16'h0300, 16'd1,  16'd1,  16'd1,  16'd1);
        ql[3] = mk_desc(8'd1, 16'h0400, 16'd20, 16'd30, 16'd10, 16'd15);
        for (int k = 0; k < 4; k++) push_desc(ql[k], 1'b1);
        check_csr("t3_qfull", ADDR_STATUS, 32'h0001_0402);
        push_desc(mk_desc(8'd0, 16'h0200, 16'd8, 16'd8, 16'd4, 16'd4), 1'b0);
        check_csr("t3_ovf", ADDR_IRQ, 32'h4);
        check_csr("t3_qcount_after_ovf", ADDR_STATUS, 32'h0001_0402);
        csr_wr(ADDR_IRQ, 32'h4);
        d6 = mk_desc(8'd1, 16'h0240, 16'd33, 16'd17, 16'd16, 16'd8);
        load_desc(d6);
        exp_q.push_back(d6);
        b_en = 1'b1;
        csr_wr(ADDR_CTRL, {16'h0, d6.mode, 6'h0, b_irq_en, b_en});
        w = 0;
        while (core_start === '0 && w < 20) begin
            tick();
            w++;
        end
        check_val("t3_launch_seen", 32'(core_start != '0), 32'd1);
        cs = core_start;
        csr_wr(ADDR_PUSH, 32'h0);
        check_csr("t3_status_push_at_launch", ADDR_STATUS, 32'h0000_0403);
        check_csr("t3_no_ovf", ADDR_IRQ, 32'h0);
        core_done = cs;
        tick();
        core_done = '0;
        for (int k = 0; k < 4; k++) begin
            run_job(k + 1, 8'd1, (k == 3), gap);
            check_val($sformatf("t3_gap_%0d", k), 32'(gap), 32'd1);
        end
        check_csr("t4_done_set_wins", ADDR_IRQ, 32'h1);
        check_csr("t3_jobs_done", ADDR_JOBS_DONE, 32'd6);
        check_csr("t3_status_drained", ADDR_STATUS, 32'h0001_0004);

        // Watchdog
        csr_wr(ADDR_PERF_CYC, 32'h0);
        csr_wr(ADDR_IRQ, 32'hF);
        wd = mk_desc(8'd0, 16'h0200, 16'd16, 16'd16, 16'd8, 16'd8);
        push_desc(wd, 1'b1);
        w = 0;
        while (core_start === '0 && w < 20) begin
            tick();
            w++;
        end
        check_val("t5_launch_seen", 32'(core_start != '0), 32'd1);
        tick();
        for (int i = 1; i < int'(TMO_CYC); i++) tick();
        check_csr("t5_busy_run16", ADDR_STATUS, 32'h0000_0005);
        check_csr("t5_no_tmo_yet", ADDR_IRQ, 32'h0);
        tick();
        check_csr("t5_idle", ADDR_STATUS, 32'h0000_0004);
        check_csr("t5_tmo", ADDR_IRQ, 32'h8);
        check_csr("t5_jobs_done", ADDR_JOBS_DONE, 32'd6);
        check_csr("t5_perf_cyc", ADDR_PERF_CYC, 32'd16);
        check_val("t5_irq", 32'(irq), 32'd1);

        // Asynchronous reset during RUN
        rj = mk_desc(8'd1, 16'h0200, 16'd10, 16'd10, 16'd5, 16'd5);
        push_desc(rj, 1'b1);
        w = 0;
        while (core_start === '0 && w < 20) begin
            tick();
            w++;
        end
        tick();
        tick();
        check_csr("t6_busy_before", ADDR_STATUS, 32'h0001_0005);
        check_val("t6_irq_before", 32'(irq), 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        check_val("t6_irq", 32'(irq), 32'd0);
        check_val("t6_core_start", 32'(core_start), 32'd0);
        check_val("t6_job_in_w", 32'(job_in_w), 32'd0);
        check_val("t6_job_out_h", 32'(job_out_h), 32'd0);
        check_val("t6_job_scale_q", 32'(job_scale_q), 32'd0);
        check_csr("t6_status", ADDR_STATUS, 32'h0000_0004);
        check_csr("t6_irq_flags", ADDR_IRQ, 32'h0);
        check_csr("t6_jobs_done", ADDR_JOBS_DONE, 32'd0);
        tick();
        check_val("t6_start_in_reset", 32'(core_start), 32'd0);
        rst_n = 1'b1;
        tick();

        check_val("sb_drained", 32'(exp_q.size()), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
